// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a combinational-read memory (slave).
// word_idx is the aliased word index the memory decodes; addresses outside the window wrap through it.
interface mips_fetch_stage_if #(
    parameter int unsigned IMEM_AW = 10
);
    logic [31:0]        imem_addr;
    logic [31:0]        imem_instr;
    logic [IMEM_AW-1:0] word_idx;

    assign word_idx = imem_addr[IMEM_AW+1:2];

    modport master (
        output imem_addr,
        input  imem_instr
    );

    modport slave (
        input  imem_addr,
        input  word_idx,
        output imem_instr
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS32 IF stage: PC register, instruction-memory address, IF/ID pipeline register,
// stall/flush/redirect handling, sticky misaligned-target flag and accepted-instruction counter.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    mips_fetch_stage_if.master     imem,
    output logic [31:0]            ifid_instr_o,
    output logic [31:0]            ifid_pc_o,
    output logic [31:0]            ifid_pc4_o,
    output logic                   ifid_valid_o,
    output logic                   misalign_o,
    output logic [31:0]            fetch_cnt_o
);

    if (IMEM_AW < 1 || IMEM_AW > 30) begin : g_bad_imem_aw
        $error("mips_fetch_stage: IMEM_AW must be in 1..30");
    end

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        bubble;

    assign pc_plus4       = pc + 32'd4;
    assign bubble         = flush_i | redirect_i;
    assign imem.imem_addr = pc;

    // PC: redirect beats stall; targets are forced word-aligned, misalignment only flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            misalign_o <= 1'b0;
        end else if (redirect_i) begin
            pc         <= {redirect_pc_i[31:2], 2'b00};
            misalign_o <= misalign_o | (redirect_pc_i[1:0] != 2'b00);
        end else if (!stall_i) begin
            pc         <= pc_plus4;
        end
    end

    // IF/ID: a bubble keeps pc/pc4 so ID still sees the last real address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_o <= '0;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
            fetch_cnt_o  <= '0;
        end else if (bubble) begin
            ifid_instr_o <= '0;
            ifid_valid_o <= 1'b0;
        end else if (!stall_i) begin
            ifid_instr_o <= imem.imem_instr;
            ifid_pc_o    <= pc;
            ifid_pc4_o   <= pc_plus4;
            ifid_valid_o <= 1'b1;
            fetch_cnt_o  <= fetch_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed self-checking bench for mips_fetch_stage with a combinational instruction-memory model.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] mem [1024];

    mips_fetch_stage_if #(.IMEM_AW(10)) bus ();

    assign bus.imem_instr = mem[bus.word_idx];

    mips_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus.master),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_valid_o  (ifid_valid_o),
        .misalign_o    (misalign_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] pc4, input logic valid,
                               input logic [31:0] cnt);
        check({tag, ".addr"},  bus.imem_addr,         addr);
        check({tag, ".instr"}, ifid_instr_o,          instr);
        check({tag, ".pc"},    ifid_pc_o,             pc);
        check({tag, ".pc4"},   ifid_pc4_o,            pc4);
        check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
        check({tag, ".cnt"},   fetch_cnt_o,           cnt);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[0] = 32'h0211_4020;
        mem[1] = 32'h0113_4821;
        mem[2] = 32'h0294_5022;
        mem[3] = 32'h0157_5823;

        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        #2;
        check_state("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        check("reset.mis", {31'd0, misalign_o}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // sequential fetch from reset
        tick(); check_state("seq0", 32'h4, 32'h0211_4020, 32'h0, 32'h4, 1'b1, 32'd1);
        tick(); check_state("seq1", 32'h8, 32'h0113_4821, 32'h4, 32'h8, 1'b1, 32'd2);

        // stall two cycles at pc=8
        stall_i = 1'b1;
        tick(); check_state("stall0", 32'h8, 32'h0113_4821, 32'h4, 32'h8, 1'b1, 32'd2);
        tick(); check_state("stall1", 32'h8, 32'h0113_4821, 32'h4, 32'h8, 1'b1, 32'd2);
        stall_i = 1'b0;
        tick(); check_state("seq2", 32'hC, 32'h0294_5022, 32'h8, 32'hC, 1'b1, 32'd3);

        // redirect to 0x40 while pc=0xC squashes the wrong-path fetch
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick(); check_state("redir40", 32'h40, 32'h0, 32'h8, 32'hC, 1'b0, 32'd3);
        redirect_i = 1'b0;
        tick(); check_state("tgt40", 32'h44, 32'hC0DE_0010, 32'h40, 32'h44, 1'b1, 32'd4);

        // redirect and stall together
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h20;
        tick(); check_state("redirstall", 32'h20, 32'h0, 32'h40, 32'h44, 1'b0, 32'd4);
        redirect_i = 1'b0; stall_i = 1'b0;
        tick(); check_state("tgt20", 32'h24, 32'hC0DE_0008, 32'h20, 32'h24, 1'b1, 32'd5);

        // flush and stall without redirect: PC holds, IF/ID bubbled
        flush_i = 1'b1; stall_i = 1'b1;
        tick(); check_state("flushstall", 32'h24, 32'h0, 32'h20, 32'h24, 1'b0, 32'd5);
        flush_i = 1'b0; stall_i = 1'b0;
        tick(); check_state("after_fs", 32'h28, 32'hC0DE_0009, 32'h24, 32'h28, 1'b1, 32'd6);

        // plain flush: PC still advances
        flush_i = 1'b1;
        tick(); check_state("flush", 32'h2C, 32'h0, 32'h24, 32'h28, 1'b0, 32'd6);
        flush_i = 1'b0;
        check("mis.pre", {31'd0, misalign_o}, 32'd0);

        // misaligned target is aligned and flagged
        redirect_i = 1'b1; redirect_pc_i = 32'h22;
        tick(); check_state("redir22", 32'h20, 32'h0, 32'h24, 32'h28, 1'b0, 32'd6);
        check("mis.set", {31'd0, misalign_o}, 32'd1);
        redirect_i = 1'b0;
        tick(); check_state("tgt22", 32'h24, 32'hC0DE_0008, 32'h20, 32'h24, 1'b1, 32'd7);
        check("mis.hold", {31'd0, misalign_o}, 32'd1);

        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick(); check("redir100.addr", bus.imem_addr, 32'h100);
        check("mis.sticky", {31'd0, misalign_o}, 32'd1);

        // top of address space wraps to 0
        redirect_pc_i = 32'hFFFF_FFFC;
        tick(); check_state("redirtop", 32'hFFFF_FFFC, 32'h0, 32'h20, 32'h24, 1'b0, 32'd7);
        redirect_i = 1'b0;
        tick(); check_state("top", 32'h0, 32'hC0DE_03FF, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd8);
        tick(); check_state("wrap0", 32'h4, 32'h0211_4020, 32'h0, 32'h4, 1'b1, 32'd9);

        // async reset mid-stall
        stall_i = 1'b1;
        tick(); check_state("prerst", 32'h4, 32'h0211_4020, 32'h0, 32'h4, 1'b1, 32'd9);
        #2 rst_n = 1'b0;
        #1;
        check_state("asyncrst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        check("asyncrst.mis", {31'd0, misalign_o}, 32'd0);
        stall_i = 1'b0;
        tick(); check_state("inrst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
